pmp: RTL and testbench
======================

PMP -- requirements
Module: pmp

Interface
REQ-001 SHALL have parameter NUM_REGION, default 4, number of implemented regions (legal 1..4; unimplemented region registers read 0 and ignore writes).
REQ-002 SHALL have parameter CNT_W, default 16, width of the saturating fault counter.
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_i  input  1  bus slave access request.
REQ-006 SHALL have port we_i  input  1  bus slave write flag.
REQ-007 SHALL have port addr_i  input  32  bus slave address (bits 31:28 already zeroed by bus).
REQ-008 SHALL have port data_i  input  32  bus slave write data.
REQ-009 SHALL have port data_o  output  32  bus slave read data.
REQ-010 SHALL have port ack_o  output  1  bus slave access complete.
REQ-011 SHALL have port chk_req_i  input  1  checked-master (core data port) request.
REQ-012 SHALL have port chk_we_i  input  1  checked-master write flag.
REQ-013 SHALL have port chk_addr_i  input  32  checked-master address.
REQ-014 SHALL have port pmp_exception_o  output  1  access violation, feeds bus write-suppress input.

Function
REQ-015 SHALL implement per region i: cfg_i (8b: bit0 R, bit1 W, bit2 EN, bit7 L, others read 0), base_i (32b), limit_i (32b).
REQ-016 SHALL decode word offsets addr_i[7:0]: 0x00+4i cfg_i, 0x10+4i base_i, 0x20+4i limit_i, 0x30 status, 0x34 fault_addr, 0x38 fault_cnt; addr_i[27:8]!=0 or other offsets unmapped (read 0, write ignored).
REQ-017 SHALL drive ack_o = req_i combinationally (zero-wait-state) and data_o = selected register when req_i & !we_i, else 0.
REQ-018 SHALL commit writes on the clk edge where req_i & we_i.
REQ-019 SHALL ignore writes to cfg_i, base_i, limit_i while cfg_i.L=1; L clears only by reset.
REQ-020 SHALL treat region i as matching when cfg_i.EN=1 and base_i <= chk_addr_i < limit_i (unsigned 32-bit); base_i >= limit_i never matches.
REQ-021 SHALL select lowest-index matching region; no match SHALL permit access.
REQ-022 SHALL assert pmp_exception_o combinationally, same cycle, when chk_req_i=1 and selected region lacks W (chk_we_i=1) or R (chk_we_i=0).
REQ-023 SHALL, on a clk edge with pmp_exception_o=1, set status[0] (sticky violation), load status[1]=chk_we_i, load fault_addr=chk_addr_i, increment fault_cnt saturating at 2^CNT_W-1.
REQ-024 SHALL clear status bits written with 1 at 0x30 (W1C); simultaneous violation and W1C SHALL leave status[0]=1 and new status[1].
REQ-025 SHALL clear fault_cnt on any write to 0x38 unless a violation occurs same cycle, then fault_cnt SHALL become 1.
REQ-026 SHALL keep fault_addr read-only.

Reset
REQ-027 SHALL on rst=1 clear all cfg, base, limit, status, fault_addr, fault_cnt to 0 on the clk edge, discarding any write or violation in that cycle.
REQ-028 SHALL hold ack_o=0, data_o=0, pmp_exception_o=0 combinationally while rst=1.

Configuration
REQ-029 SHALL with macro PMP_FAULT_LOG_EN defined implement status, fault_addr, fault_cnt per REQ-023..026.
REQ-030 SHALL without PMP_FAULT_LOG_EN omit those registers: offsets 0x30..0x38 read 0, writes ignored; pmp_exception_o unaffected.

Verification
REQ-031 SHALL cover: write base0=0x1000_0000, limit0=0x1000_1000, cfg0=0x05; chk write to 0x1000_0010 -> pmp_exception_o=1 same cycle; chk read -> 0.
REQ-032 SHALL cover: cfg0=0x85 then write base0=0 -> base0 readback unchanged; after rst -> cfg0 reads 0.
REQ-033 SHALL cover: overlapping region0 (R only) and region1 (RW) both match 0x1000_0020; write -> exception=1 (region0 wins); disable region0 -> exception=0.
REQ-034 SHALL cover: three violations at 0x1000_0004/8/C -> fault_cnt=3, fault_addr=0x1000_000C, status=0x3 (last was write).
REQ-035 SHALL cover: W1C 0x1 to status coincident with read violation -> status=0x1 next cycle; fault_cnt preset near max saturates at 0xFFFF.
REQ-036 SHALL cover: build without PMP_FAULT_LOG_EN -> violation still asserts exception, reads of 0x30/0x34/0x38 return 0.

Source files
------------

// File: rtl/pmp.sv
// PMP: region-based access checker for the core data port with a bus-slave register file.
// Optional fault logging (status / fault_addr / fault_cnt) is built only with macro PMP_FAULT_LOG_EN.
module pmp #(
  parameter int NUM_REGION = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        chk_req_i,
  input  logic        chk_we_i,
  input  logic [31:0] chk_addr_i,
  output logic        pmp_exception_o
);

  localparam logic [7:0] CFG_MASK = 8'h87;

  function automatic logic region_hit(input logic [7:0] cfg, input logic [31:0] base,
                                      input logic [31:0] limit, input logic [31:0] addr);
    return cfg[2] && (base <= addr) && (addr < limit);
  endfunction

  logic [7:0]  cfg_q   [4];
  logic [31:0] base_q  [4];
  logic [31:0] limit_q [4];

  logic        mapped_s;
  logic [3:0]  grp_s;
  logic [1:0]  idx_s;
  logic        reg_ok_s;
  logic        wr_s;
  logic [1:0]  perm_s;
  logic        exc_s;
  logic [31:0] rdata_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^addr_i[31:28];
  assign mapped_s      = (addr_i[27:8] == 20'h0) && (addr_i[1:0] == 2'b00);
  assign grp_s         = addr_i[7:4];
  assign idx_s         = addr_i[3:2];
  assign reg_ok_s      = (int'(idx_s) < NUM_REGION);
  assign wr_s          = req_i && we_i && mapped_s && !rst;

  // Lowest-index matching region decides; no match leaves both permissions granted.
  always_comb begin
    perm_s = 2'b11;
    for (int i = NUM_REGION - 1; i >= 0; i--) begin
      perm_s = region_hit(cfg_q[i], base_q[i], limit_q[i], chk_addr_i) ? cfg_q[i][1:0] : perm_s;
    end
  end

  assign exc_s           = !rst && chk_req_i && (chk_we_i ? !perm_s[1] : !perm_s[0]);
  assign pmp_exception_o = exc_s;
  assign ack_o           = req_i && !rst;
  assign data_o          = (req_i && !we_i && !rst) ? rdata_s : 32'h0;

  // Region register file; a set L bit freezes the whole region until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cfg_q[i]   <= 8'h00;
        base_q[i]  <= 32'h0;
        limit_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NUM_REGION; i++) begin
        if (wr_s && (int'(idx_s) == i) && !cfg_q[i][7]) begin
          case (grp_s)
            4'h0:    cfg_q[i]   <= data_i[7:0] & CFG_MASK;
            4'h1:    base_q[i]  <= data_i;
            4'h2:    limit_q[i] <= data_i;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PMP_FAULT_LOG_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       status_q, status_d;
  logic [31:0]      fault_addr_q;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             status_wr_s;
  logic             cnt_wr_s;

  assign status_wr_s = wr_s && (grp_s == 4'h3) && (idx_s == 2'd0);
  assign cnt_wr_s    = wr_s && (grp_s == 4'h3) && (idx_s == 2'd2);

  // A violation in the same cycle wins over W1C and over the counter clear.
  always_comb begin
    status_d    = status_q;
    fault_cnt_d = fault_cnt_q;
    if (exc_s) begin
      status_d = {chk_we_i, 1'b1};
    end else if (status_wr_s) begin
      status_d = status_q & ~data_i[1:0];
    end else begin
      status_d = status_q;
    end
    if (cnt_wr_s) begin
      fault_cnt_d = exc_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (exc_s && (fault_cnt_q != CNT_MAX)) begin
      fault_cnt_d = fault_cnt_q + CNT_ONE;
    end else begin
      fault_cnt_d = fault_cnt_q;
    end
  end

  // Fault log state.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q     <= 2'b00;
      fault_addr_q <= 32'h0;
      fault_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      status_q    <= status_d;
      fault_cnt_q <= fault_cnt_d;
      if (exc_s) begin
        fault_addr_q <= chk_addr_i;
      end else begin
        fault_addr_q <= fault_addr_q;
      end
    end
  end
`endif

  // Register read mux.
  always_comb begin
    rdata_s = 32'h0;
    if (mapped_s) begin
      case (grp_s)
        4'h0:    rdata_s = reg_ok_s ? {24'h0, cfg_q[idx_s]} : 32'h0;
        4'h1:    rdata_s = reg_ok_s ? base_q[idx_s] : 32'h0;
        4'h2:    rdata_s = reg_ok_s ? limit_q[idx_s] : 32'h0;
`ifdef PMP_FAULT_LOG_EN
        4'h3: begin
          case (idx_s)
            2'd0:    rdata_s = {30'h0, status_q};
            2'd1:    rdata_s = fault_addr_q;
            2'd2:    rdata_s = 32'(fault_cnt_q);
            default: rdata_s = 32'h0;
          endcase
        end
`endif
        default: rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

endmodule

// File: tb/tb_pmp.sv
// Self-checking bench for pmp: expectations queued at stimulus time, compared as outputs appear.
module tb_pmp;

  localparam int TB_CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        chk_req_i = 1'b0;
  logic        chk_we_i = 1'b0;
  logic [31:0] chk_addr_i = 32'h0;
  logic        pmp_exception_o;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          total = 0;
  int          bad = 0;

  pmp #(.NUM_REGION(4), .CNT_W(TB_CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .data_i          (data_i),
    .data_o          (data_o),
    .ack_o           (ack_o),
    .chk_req_i       (chk_req_i),
    .chk_we_i        (chk_we_i),
    .chk_addr_i      (chk_addr_i),
    .pmp_exception_o (pmp_exception_o)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus on both ports; outputs sampled mid-cycle.
  task automatic cycle(input logic r, input logic br, input logic bw, input logic [31:0] a,
                       input logic [31:0] d, input logic cr, input logic cw, input logic [31:0] ca,
                       output logic [31:0] rd, output logic ex, output logic ak);
    @(negedge clk);
    rst = r; req_i = br; we_i = bw; addr_i = a; data_i = d;
    chk_req_i = cr; chk_we_i = cw; chk_addr_i = ca;
    #1;
    rd = data_o; ex = pmp_exception_o; ak = ack_o;
    @(posedge clk);
    #1;
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; chk_req_i = 1'b0; chk_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic x, k;
    cycle(1'b0, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 32'h0, r, x, k);
  endtask

  task automatic do_reset();
    logic [31:0] r; logic x, k;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, r, x, k);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] v, input string n);
    logic [31:0] r; logic x, k;
    exp_q.push_back(exp_t'{name: n, val: v});
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, r, x, k);
    obs_q.push_back(r);
  endtask

  task automatic chk_exp(input logic cw, input logic [31:0] ca, input logic e, input string n);
    logic [31:0] r; logic x, k;
    exp_q.push_back(exp_t'{name: n, val: {31'h0, e}});
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, cw, ca, r, x, k);
    obs_q.push_back({31'h0, x});
  endtask

  task automatic test_reset();
    logic [31:0] r; logic x, k;
    exp_t e; logic [31:0] o;
    wr(32'h10, 32'h1000_0000);
    wr(32'h20, 32'h1000_1000);
    wr(32'h00, 32'h0000_0005);
    exp_q.push_back(exp_t'{name: "rst_ack", val: 32'h0});
    exp_q.push_back(exp_t'{name: "rst_data", val: 32'h0});
    exp_q.push_back(exp_t'{name: "rst_exc", val: 32'h0});
    cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h1000_0010, r, x, k);
    obs_q.push_back({31'h0, k});
    obs_q.push_back(r);
    obs_q.push_back({31'h0, x});
    rd_exp(32'h00, 32'h0, "rst_cfg0");
    rd_exp(32'h10, 32'h0, "rst_base0");
    exp_q.push_back(exp_t'{name: "ack_after_rst", val: 32'h1});
    cycle(1'b0, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0, r, x, k);
    obs_q.push_back({31'h0, k});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_basic();
    exp_t e; logic [31:0] o;
    do_reset();
    wr(32'h10, 32'h1000_0000);
    wr(32'h20, 32'h1000_1000);
    wr(32'h00, 32'h0000_007D);
    rd_exp(32'h00, 32'h05, "cfg0_masked");
    rd_exp(32'h10, 32'h1000_0000, "base0");
    rd_exp(32'h20, 32'h1000_1000, "limit0");
    chk_exp(1'b1, 32'h1000_0010, 1'b1, "wr_viol");
    chk_exp(1'b0, 32'h1000_0010, 1'b0, "rd_ok");
    chk_exp(1'b1, 32'h1000_0000, 1'b1, "wr_at_base");
    chk_exp(1'b1, 32'h1000_0FFC, 1'b1, "wr_below_limit");
    chk_exp(1'b1, 32'h1000_1000, 1'b0, "wr_at_limit");
    chk_exp(1'b1, 32'h0FFF_FFFC, 1'b0, "wr_below_base");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_lock();
    exp_t e; logic [31:0] o;
    do_reset();
    wr(32'h14, 32'h1000_0000);
    wr(32'h04, 32'h0000_0085);
    wr(32'h14, 32'h0000_0000);
    rd_exp(32'h14, 32'h1000_0000, "locked_base1");
    wr(32'h04, 32'h0000_0000);
    rd_exp(32'h04, 32'h85, "locked_cfg1");
    do_reset();
    rd_exp(32'h04, 32'h0, "cfg1_after_rst");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_priority();
    exp_t e; logic [31:0] o;
    do_reset();
    wr(32'h10, 32'h1000_0000); wr(32'h20, 32'h1000_0100); wr(32'h00, 32'h05);
    wr(32'h14, 32'h1000_0000); wr(32'h24, 32'h1000_1000); wr(32'h04, 32'h07);
    wr(32'h18, 32'h2000_0000); wr(32'h28, 32'h2000_0000); wr(32'h08, 32'h04);
    chk_exp(1'b1, 32'h1000_0020, 1'b1, "prio_r0_wins");
    chk_exp(1'b1, 32'h1000_0200, 1'b0, "prio_r1_only");
    chk_exp(1'b0, 32'h2000_0000, 1'b0, "empty_region");
    wr(32'h00, 32'h00);
    chk_exp(1'b1, 32'h1000_0020, 1'b0, "r0_disabled");
    rd_exp(32'h0C, 32'h0, "cfg3_idle");
    wr(32'h0000_0110, 32'hDEAD_BEEF);
    rd_exp(32'h10, 32'h1000_0000, "unmapped_wr");
    rd_exp(32'h0000_0110, 32'h0, "unmapped_rd_hi");
    rd_exp(32'h40, 32'h0, "unmapped_rd_off");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

`ifdef PMP_FAULT_LOG_EN
  task automatic test_fault_log();
    logic [31:0] r; logic x, k;
    exp_t e; logic [31:0] o;
    do_reset();
    wr(32'h10, 32'h1000_0000); wr(32'h20, 32'h1000_1000); wr(32'h00, 32'h05);
    wr(32'h14, 32'h2000_0000); wr(32'h24, 32'h2000_1000); wr(32'h04, 32'h04);
    chk_exp(1'b1, 32'h1000_0004, 1'b1, "viol1");
    chk_exp(1'b1, 32'h1000_0008, 1'b1, "viol2");
    chk_exp(1'b1, 32'h1000_000C, 1'b1, "viol3");
    rd_exp(32'h38, 32'h3, "fault_cnt3");
    rd_exp(32'h34, 32'h1000_000C, "fault_addr");
    rd_exp(32'h30, 32'h3, "status3");
    wr(32'h34, 32'h0);
    rd_exp(32'h34, 32'h1000_000C, "fault_addr_ro");
    exp_q.push_back(exp_t'{name: "w1c_viol_exc", val: 32'h1});
    cycle(1'b0, 1'b1, 1'b1, 32'h30, 32'h1, 1'b1, 1'b0, 32'h2000_0000, r, x, k);
    obs_q.push_back({31'h0, x});
    rd_exp(32'h30, 32'h1, "status_w1c_viol");
    rd_exp(32'h38, 32'h4, "fault_cnt4");
    wr(32'h38, 32'h0);
    rd_exp(32'h38, 32'h0, "cnt_clear");
    cycle(1'b0, 1'b1, 1'b1, 32'h38, 32'h0, 1'b1, 1'b1, 32'h1000_0000, r, x, k);
    rd_exp(32'h38, 32'h1, "cnt_clear_viol");
    wr(32'h30, 32'h3);
    rd_exp(32'h30, 32'h0, "status_w1c");
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000_0000, r, x, k);
    end
    rd_exp(32'h38, (32'h1 << TB_CNT_W) - 32'h1, "cnt_saturate");
    exp_q.push_back(exp_t'{name: "rst_viol_exc", val: 32'h0});
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000_0000, r, x, k);
    obs_q.push_back({31'h0, x});
    rd_exp(32'h38, 32'h0, "cnt_after_rst");
    rd_exp(32'h30, 32'h0, "status_after_rst");
    rd_exp(32'h34, 32'h0, "faddr_after_rst");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask
`else
  task automatic test_no_log();
    exp_t e; logic [31:0] o;
    do_reset();
    wr(32'h10, 32'h1000_0000); wr(32'h20, 32'h1000_1000); wr(32'h00, 32'h05);
    chk_exp(1'b1, 32'h1000_0004, 1'b1, "nolog_viol");
    wr(32'h30, 32'h3);
    wr(32'h38, 32'h0);
    rd_exp(32'h30, 32'h0, "nolog_status");
    rd_exp(32'h34, 32'h0, "nolog_faddr");
    rd_exp(32'h38, 32'h0, "nolog_cnt");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_lock();
    test_priority();
`ifdef PMP_FAULT_LOG_EN
    test_fault_log();
`else
    test_no_log();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
